// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: function codes,
// default operand width and the register-address width helper.
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FUNC_W     = 4;

  // Function codes understood by the ALU; the issue stage passes them through.
  localparam logic [FUNC_W-1:0] FUNC_ADD  = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_ID   = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_NOT  = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_NAND = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_NOR  = 4'd7;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 4'd8;
  localparam logic [FUNC_W-1:0] FUNC_XNOR = 4'd9;
  localparam logic [FUNC_W-1:0] FUNC_LLS  = 4'd10;
  localparam logic [FUNC_W-1:0] FUNC_LRS  = 4'd11;
  localparam logic [FUNC_W-1:0] FUNC_ALS  = 4'd12;
  localparam logic [FUNC_W-1:0] FUNC_ARS  = 4'd13;
  localparam logic [FUNC_W-1:0] FUNC_TCP  = 4'd14;
  localparam logic [FUNC_W-1:0] FUNC_ZERO = 4'd15;

  // Register address width; a single-entry file still needs one address bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: one write port, three combinational read
// ports (two operand reads plus a debug read), synchronous active-high reset.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_COUNT = 4,
  parameter int AW        = addr_w(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  input  logic [AW-1:0]     raddr_d,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_d
);

  logic [REG_COUNT-1:0][DATA_W-1:0] regs_q, regs_d;

  // Next register contents: only the addressed entry changes on a write.
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  // Register storage; reset clears every entry, register 0 included.
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  assign rdata_d = regs_q[raddr_d];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue and writeback stage around a combinational ALU. One execute slot
// feeds the ALU; its result is written back when the consumer accepts it.
// Build option: define ALU_ISSUE_FWD_EN to forward the retiring result into
// the issuing instruction's operands; otherwise dependent instructions stall
// until the producer has written the register file.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int REG_COUNT = 4,
  localparam int AW        = addr_w(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  // instruction in
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [AW-1:0]     in_rs,
  input  logic [AW-1:0]     in_rt,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  // ALU interface
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [FUNC_W-1:0] alu_FuncCode,
  input  logic [DATA_W-1:0] alu_C,
  input  logic              alu_OverflowFlag,
  // result out
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [AW-1:0]     res_rd,
  output logic              res_ovf,
  // status / debug
  output logic              ovf_sticky,
  input  logic              ovf_clear,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [FUNC_W-1:0] ex_func_q, ex_func_d;
  logic [AW-1:0]     ex_rd_q, ex_rd_d;
  logic              ovf_q, ovf_d;

  logic              fire, accept, hazard;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] op_a, op_b;

  assign fire = ex_valid_q && res_ready;

  alu_regfile #(
    .DATA_W   (DATA_W),
    .REG_COUNT(REG_COUNT),
    .AW       (AW)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (fire),
    .waddr  (ex_rd_q),
    .wdata  (alu_C),
    .raddr_a(in_rs),
    .raddr_b(in_rt),
    .raddr_d(dbg_addr),
    .rdata_a(rf_a),
    .rdata_b(rf_b),
    .rdata_d(dbg_data)
  );

`ifdef ALU_ISSUE_FWD_EN
  // Operand select: the result retiring this cycle overrides the stale entry.
  always_comb begin
    op_a   = (fire && (in_rs == ex_rd_q)) ? alu_C : rf_a;
    op_b   = (fire && (in_rt == ex_rd_q)) ? alu_C : rf_b;
    hazard = 1'b0;
  end
`else
  // Operand select and stall: any read of the pending destination waits
  // until the producer has retired and the file holds the new value.
  always_comb begin
    op_a   = rf_a;
    op_b   = rf_b;
    hazard = ex_valid_q && ((in_rs == ex_rd_q) || (!in_use_imm && (in_rt == ex_rd_q)));
  end
`endif

  assign in_ready = (!ex_valid_q || fire) && !hazard;
  assign accept   = in_valid && in_ready;

  // Execute slot and sticky overflow next-state.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_func_d  = ex_func_q;
    ex_rd_d    = ex_rd_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_a_d     = op_a;
      ex_b_d     = in_use_imm ? in_imm : op_b;
      ex_func_d  = in_func;
      ex_rd_d    = in_rd;
    end else if (fire) begin
      ex_valid_d = 1'b0;
    end

    // A fresh overflow wins over a clear arriving in the same cycle.
    ovf_d = ovf_q;
    if (ovf_clear)                ovf_d = 1'b0;
    if (fire && alu_OverflowFlag) ovf_d = 1'b1;
  end

  // Execute slot and status registers; reset drops any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_func_q  <= '0;
      ex_rd_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_func_q  <= ex_func_d;
      ex_rd_q    <= ex_rd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign alu_A        = ex_a_q;
  assign alu_B        = ex_b_q;
  assign alu_FuncCode = ex_func_q;
  assign res_valid    = ex_valid_q;
  assign res_data     = alu_C;
  assign res_rd       = ex_rd_q;
  assign res_ovf      = alu_OverflowFlag;
  assign ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: a behavioural ALU drives the DUT's
// ALU port, and an architectural model (register array + one pending slot)
// predicts every output each cycle. Directed scenarios add literal checks.
module tb_alu_issue_unit;

  localparam int DW = 16;
  localparam int RC = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, in_ready, in_use_imm;
  logic [3:0]    in_func, alu_func;
  logic [AW-1:0] in_rs, in_rt, in_rd, res_rd, dbg_addr;
  logic [DW-1:0] in_imm, alu_a, alu_b, alu_c, res_data, dbg_data;
  logic          alu_ovf, res_valid, res_ready, res_ovf, ovf_sticky, ovf_clear;

  alu_issue_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_A(alu_a), .alu_B(alu_b), .alu_FuncCode(alu_func),
    .alu_C(alu_c), .alu_OverflowFlag(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_ovf(res_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: {overflow, result}.
  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] f);
    logic [15:0] c;
    logic        o;
    o = 1'b0;
    case (f)
      4'd0:  begin c = a + b; o = (a[15] == b[15]) && (c[15] != a[15]); end
      4'd1:  begin c = a - b; o = (a[15] != b[15]) && (c[15] != a[15]); end
      4'd2:  c = a;
      4'd3:  c = ~a;
      4'd4:  c = a & b;
      4'd5:  c = a | b;
      4'd6:  c = ~(a & b);
      4'd7:  c = ~(a | b);
      4'd8:  c = a ^ b;
      4'd9:  c = ~(a ^ b);
      4'd10: c = a << b[3:0];
      4'd11: c = a >> b[3:0];
      4'd12: c = a <<< b[3:0];
      4'd13: c = 16'($signed(a) >>> b[3:0]);
      4'd14: begin c = -a; o = (a == 16'h8000); end
      default: c = 16'h0000;
    endcase
    return {o, c};
  endfunction

  always_comb {alu_ovf, alu_c} = alu_f(alu_a, alu_b, alu_func);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: register contents, one pending instruction, sticky bit.
  bit            model_ok = 1'b0;
  logic [DW-1:0] m_regs[RC];
  logic          m_v, m_sticky;
  logic [DW-1:0] m_a, m_b;
  logic [3:0]    m_f;
  logic [AW-1:0] m_rd;

  // Compare all outputs against the model, advance the model, cross one edge.
  task automatic tick();
    logic          fire, rdy, haz, acc;
    logic [16:0]   r;
    logic [DW-1:0] nregs[RC];
    fire = m_v && res_ready;
    haz  = 1'b0;
`ifndef ALU_ISSUE_FWD_EN
    // A pending write to a register this instruction reads must land first.
    haz  = m_v && ((in_rs == m_rd) || (!in_use_imm && (in_rt == m_rd)));
`endif
    rdy  = (!m_v || res_ready) && !haz;
    r    = alu_f(m_a, m_b, m_f);
    if (model_ok) begin
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("res_valid", 32'(res_valid), 32'(m_v));
      if (m_v) begin
        chk("res_data", 32'(res_data), 32'(r[15:0]));
        chk("res_ovf", 32'(res_ovf), 32'(r[16]));
        chk("res_rd", 32'(res_rd), 32'(m_rd));
        chk("alu_A", 32'(alu_a), 32'(m_a));
        chk("alu_B", 32'(alu_b), 32'(m_b));
        chk("alu_func", 32'(alu_func), 32'(m_f));
      end
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
      chk("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
    end
    if (reset) begin
      model_ok = 1'b1;
      m_v = 1'b0; m_sticky = 1'b0; m_a = '0; m_b = '0; m_f = '0; m_rd = '0;
      for (int i = 0; i < RC; i++) m_regs[i] = '0;
    end else if (model_ok) begin
      nregs = m_regs;
      if (fire) nregs[m_rd] = r[15:0];
      if (ovf_clear) m_sticky = 1'b0;
      if (fire && r[16]) m_sticky = 1'b1;
      acc = in_valid && rdy;
      // An accepted instruction sees every older result, including the one
      // retiring on this same edge.
      if (acc) begin
        m_v  = 1'b1;
        m_a  = nregs[in_rs];
        m_b  = in_use_imm ? in_imm : nregs[in_rt];
        m_f  = in_func;
        m_rd = in_rd;
      end else if (fire) begin
        m_v = 1'b0;
      end
      m_regs = nregs;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    in_valid = 1'b0; res_ready = rr; ovf_clear = 1'b0; reset = 1'b0;
  endtask

  // Offer one instruction (consumer ready) until accepted; report stall cycles.
  task automatic issue(input logic [3:0] f, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic ui, input logic [DW-1:0] imm,
                       output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    in_valid = 1'b1; in_func = f; in_rs = rs; in_rt = rt; in_rd = rd;
    in_use_imm = ui; in_imm = imm; res_ready = 1'b1; ovf_clear = 1'b0; reset = 1'b0;
    for (int k = 0; k < 4 && !acc; k++) begin
      #1;
      acc = in_ready;
      if (!acc) stalls++;
      tick();
    end
    if (!acc) chk("issue_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
  endtask

  int st;
  int exp_st;

  initial begin
`ifdef ALU_ISSUE_FWD_EN
    exp_st = 0;
`else
    exp_st = 1;
`endif
    in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_use_imm = 1'b0; in_imm = '0;
    dbg_addr = '0;
    idle(1'b1);
    reset = 1'b1;
    #1;
    tick();

    // Reset state.
    idle(1'b1); #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_sticky", 32'(ovf_sticky), 32'(0));
    chk("rst_alu_A", 32'(alu_a), 32'(0));
    chk("rst_alu_B", 32'(alu_b), 32'(0));
    chk("rst_alu_func", 32'(alu_func), 32'(0));
    tick();

    // ADD r1 = r0 + 5.
    issue(4'd0, 2'd0, 2'd0, 2'd1, 1'b1, 16'h0005, st);
    idle(1'b1); #1;
    chk("add_valid", 32'(res_valid), 32'(1));
    chk("add_data", 32'(res_data), 32'h0005);
    chk("add_rd", 32'(res_rd), 32'(1));
    tick();
    idle(1'b1); dbg_addr = 2'd1; #1;
    chk("add_wb", 32'(dbg_data), 32'h0005);
    tick();

    // Dependent pair: r1 = 0x7FFF, then r2 = r1 + 1 overflows.
    issue(4'd0, 2'd0, 2'd0, 2'd1, 1'b1, 16'h7FFF, st);
    issue(4'd0, 2'd1, 2'd0, 2'd2, 1'b1, 16'h0001, st);
    chk("dep_stalls", 32'(st), 32'(exp_st));
    idle(1'b1); #1;
    chk("dep_data", 32'(res_data), 32'h8000);
    chk("dep_ovf", 32'(res_ovf), 32'(1));
    tick();
    idle(1'b1); #1;
    chk("dep_sticky", 32'(ovf_sticky), 32'(1));
    tick();

    // Backpressure: result held for three cycles, written on the fourth.
    issue(4'd0, 2'd0, 2'd0, 2'd3, 1'b1, 16'h1234, st);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0); in_valid = 1'b1; in_rs = 2'd0; in_rd = 2'd0; in_use_imm = 1'b1;
      dbg_addr = 2'd3; #1;
      chk("bp_valid", 32'(res_valid), 32'(1));
      chk("bp_data", 32'(res_data), 32'h1234);
      chk("bp_ready", 32'(in_ready), 32'(0));
      chk("bp_noreg", 32'(dbg_data), 32'h0000);
      tick();
    end
    idle(1'b1); #1; tick();
    idle(1'b1); dbg_addr = 2'd3; #1;
    chk("bp_wb", 32'(dbg_data), 32'h1234);
    tick();

    // Sticky: clear, then overflowing fire together with clear keeps it set.
    idle(1'b1); ovf_clear = 1'b1; #1; tick();
    idle(1'b1); #1;
    chk("clr_sticky", 32'(ovf_sticky), 32'(0));
    tick();
    issue(4'd0, 2'd1, 2'd0, 2'd2, 1'b1, 16'h0001, st);
    idle(1'b1); ovf_clear = 1'b1; #1;
    chk("clr_fire_ovf", 32'(res_ovf), 32'(1));
    tick();
    idle(1'b1); ovf_clear = 1'b1; #1;
    chk("set_beats_clr", 32'(ovf_sticky), 32'(1));
    tick();
    idle(1'b1); #1;
    chk("clr_after", 32'(ovf_sticky), 32'(0));
    tick();

    // NOT then XOR chain.
    issue(4'd0, 2'd0, 2'd0, 2'd1, 1'b1, 16'h0005, st);
    issue(4'd3, 2'd1, 2'd0, 2'd3, 1'b0, 16'h0000, st);
    idle(1'b1); #1;
    chk("not_data", 32'(res_data), 32'hFFFA);
    tick();
    issue(4'd8, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0000, st);
    idle(1'b1); #1;
    chk("xor_data", 32'(res_data), 32'hFFFF);
    tick();

    // Reset with a stalled result pending and sticky set.
    issue(4'd0, 2'd1, 2'd0, 2'd2, 1'b1, 16'h0001, st);
    issue(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 16'h0009, st);
    idle(1'b0); reset = 1'b1; #1;
    chk("prerst_valid", 32'(res_valid), 32'(1));
    tick();
    idle(1'b1); #1;
    chk("mrst_valid", 32'(res_valid), 32'(0));
    chk("mrst_ready", 32'(in_ready), 32'(1));
    chk("mrst_sticky", 32'(ovf_sticky), 32'(0));
    for (int i = 0; i < RC; i++) begin
      dbg_addr = AW'(i); #1;
      chk("mrst_reg", 32'(dbg_data), 32'h0000);
    end
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 255) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_func    = 4'($urandom_range(0, 15));
      in_rs      = AW'($urandom_range(0, RC - 1));
      in_rt      = AW'($urandom_range(0, RC - 1));
      in_rd      = AW'($urandom_range(0, RC - 1));
      in_use_imm = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       in_imm = 16'h7FFF;
        1:       in_imm = 16'h8000;
        2:       in_imm = 16'h0001;
        default: in_imm = 16'($urandom);
      endcase
      res_ready  = ($urandom_range(0, 3) != 0);
      ovf_clear  = ($urandom_range(0, 7) == 0);
      dbg_addr   = AW'($urandom_range(0, RC - 1));
      #1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Issue and writeback stage wrapped around the combinational ALU. It holds a small register file and accepts one instruction per cycle through a valid/ready handshake. It reads operands, registers them into a single execute slot that drives the ALU's A, B and FuncCode inputs, and writes the ALU result back to the register file when the downstream result consumer accepts it. It also keeps a sticky overflow status.

## Interface

- data_width, 16, operand/result width; matches ALU
- reg_count, 4, number of architectural registers; address width = clog2(reg_count)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_func  in  4  ALU function code
- in_rs  in  addr  source register for A
- in_rt  in  addr  source register for B
- in_rd  in  addr  destination register
- in_use_imm  in  1  B = in_imm instead of reg[in_rt]
- in_imm  in  data_width  immediate operand
- alu_A  out  data_width  to ALU A
- alu_B  out  data_width  to ALU B
- alu_FuncCode  out  4  to ALU FuncCode
- alu_C  in  data_width  from ALU C
- alu_OverflowFlag  in  1  from ALU OverflowFlag
- res_valid  out  1  execute slot holds a result
- res_ready  in  1  consumer accepts result; fire = res_valid && res_ready
- res_data  out  data_width  = alu_C
- res_rd  out  addr  destination of the result
- res_ovf  out  1  = alu_OverflowFlag
- ovf_sticky  out  1  set on any fired result with overflow
- ovf_clear  in  1  clears ovf_sticky
- dbg_addr  in  addr  debug read address
- dbg_data  out  data_width  combinational reg[dbg_addr]

## Operation

- Execute slot registers: ex_valid, ex_A, ex_B, ex_func, ex_rd. alu_A/alu_B/alu_FuncCode are driven directly from ex_A/ex_B/ex_func.
- res_valid = ex_valid. res_data, res_ovf and res_rd pass through combinationally.
- On fire: reg[ex_rd] <= alu_C. If alu_OverflowFlag, ovf_sticky <= 1.
- in_ready = !ex_valid || fire, further gated by the hazard rule below.
- On accept: ex_valid <= 1, ex_func <= in_func, ex_rd <= in_rd, ex_A <= operand(in_rs), ex_B <= in_use_imm ? in_imm : operand(in_rt).
- On fire without accept: ex_valid <= 0.
- operand(r) reads reg[r], except when the forwarding rule in Configuration applies.
- Register 0 is an ordinary writable register.
- ovf_sticky: set has priority over a simultaneous ovf_clear.
- Reset: ex_valid = 0, all registers = 0, ovf_sticky = 0. The ex_* data registers are also cleared, so alu_A = alu_B = 0 and alu_FuncCode = 0.
- Reset mid-operation discards any pending result with no writeback.
- Reset outputs: in_ready = 1, res_valid = 0, ovf_sticky = 0.
- Function codes: ADD=0, SUB=1, ID=2, NOT=3, AND=4, OR=5, NAND=6, NOR=7, XOR=8, XNOR=9, LLS=10, LRS=11, ALS=12, ARS=13, TCP=14, ZERO=15. The block passes them through without interpreting them.

## Timing

- Instruction accepted at edge N: res_valid is high in the cycle after N. Latency 1.
- Throughput is 1 per cycle while res_ready stays high.
- res_ready low: res_valid, res_data and res_rd stay stable, in_ready = 0, no register write.
- in_ready depends combinationally on res_ready, the hazard compare and in_rs/in_rt/in_use_imm. in_ready does not depend on in_valid.
- A register write at the fire edge is visible on dbg_data in the following cycle.

## Configuration

- ALU_ISSUE_FWD_EN defined (forwarding):
  - operand(r) = alu_C when fire && r == ex_rd; otherwise reg[r].
  - in_ready never drops for hazards.
- ALU_ISSUE_FWD_EN undefined (stall):
  - in_ready = 0 while ex_valid and (in_rs == ex_rd, or (!in_use_imm and in_rt == ex_rd)).
  - The dependent instruction is accepted the cycle after the producer fires and reads the updated register.
  - Costs a one-cycle bubble.

## Structure

- Shared package alu_pkg holds:
  - FUNC_* localparams (values above)
  - default data_width
  - func-code width constant 4
  - register address width helper
- One sub-module, alu_regfile: reg_count x data_width registers, synchronous reset, one write port, three combinational read ports (rs, rt, dbg). Forwarding and hazard logic stay in alu_issue_unit.

## Test plan

- Reset, then ADD rs=0, imm=0x0005, use_imm, rd=1 → next cycle res_valid=1, res_data=0x0005, res_rd=1; after fire, dbg_data(1)=0x0005.
- ADD r1=r0+imm 0x7FFF, immediately followed by ADD r2=r1+imm 0x0001 → second result res_data=0x8000, res_ovf=1, ovf_sticky=1.
  - With ALU_ISSUE_FWD_EN: back-to-back.
  - Without it: exactly one in_ready=0 cycle.
- Result pending with res_ready=0 for 3 cycles → res_valid=1 and res_data stable, in_ready=0, register unchanged. Fire on cycle 4 writes it.
- ovf_clear=1 on the same cycle as an overflowing fire → ovf_sticky=1. ovf_clear alone on the next cycle → ovf_sticky=0.
- reset asserted while res_valid=1 and res_ready=0 → next cycle res_valid=0, in_ready=1, all dbg_data reads 0, ovf_sticky=0.
- NOT, rs=1 (0x0005), rd=3, res_ready=1, followed by XOR rs=3, rt=1 → results 0xFFFA then 0xFFFF.
